fma_seq: RTL and testbench

FMA_SEQ -- requirements
Module: fma_seq

---
 rtl/fp_pkg.sv | 29 ++
 rtl/fma_seq.sv | 101 ++++++++++
 tb/tb_fma_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared FP decode definitions: FMA-family op encodings, sequencer state
// encoding and the default latency of the external multiply-add datapath.
package fp_pkg;

  localparam int unsigned FMA_LAT_DEFAULT = 4;

  typedef enum logic [1:0] {
    OP_FMADD  = 2'b00,
    OP_FMSUB  = 2'b01,
    OP_FNMSUB = 2'b10,
    OP_FNMADD = 2'b11
  } fma_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } fma_state_e;

  // fnmsub/fnmadd negate the product, realised by flipping the sign of rs1.
  function automatic logic op_neg_product(input fma_op_e op);
    return (op == OP_FNMSUB) || (op == OP_FNMADD);
  endfunction

  function automatic logic op_neg_addend(input fma_op_e op);
    return (op == OP_FMSUB) || (op == OP_FNMADD);
  endfunction

endpackage

// File: rtl/fma_seq.sv
// FMA-family sequencer: captures sign-adjusted operands for an external
// fixed-latency multiply-add datapath and holds its result until writeback.
module fma_seq
  import fp_pkg::*;
#(
  parameter int unsigned LAT = FMA_LAT_DEFAULT,
  parameter int unsigned W   = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] rs1,
  input  logic [W-1:0] rs2,
  input  logic [W-1:0] rs3,
  output logic [W-1:0] dp_a,
  output logic [W-1:0] dp_b,
  output logic [W-1:0] dp_c,
  input  logic [W-1:0] dp_res,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

  fma_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  c_q, c_d;
  logic [W-1:0]  data_q, data_d;
  fma_op_e       op_in;

  assign op_in = fma_op_e'(op);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Only the sign bit is touched, so NaN payloads, Inf and zeros pass intact.
          a_d     = {rs1[W-1] ^ op_neg_product(op_in), rs1[W-2:0]};
          b_d     = rs2;
          c_d     = {rs3[W-1] ^ op_neg_addend(op_in), rs3[W-2:0]};
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          data_d  = dp_res;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = data_q;
  assign dp_a      = a_q;
  assign dp_b      = b_q;
  assign dp_c      = c_q;

endmodule

// File: tb/tb_fma_seq.sv
// Directed bench for fma_seq with a fixed-latency datapath model
// (bit-exact for the directed FP vectors, deterministic hash otherwise).
module tb_fma_seq;

  localparam int unsigned LAT = 4;
  localparam int unsigned W   = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rs1 = '0, rs2 = '0, rs3 = '0;
  logic [W-1:0] dp_a, dp_b, dp_c, dp_res;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fma_seq #(.LAT(LAT), .W(W)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .rs3(rs3),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_res(dp_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  // a*b+c for the directed FP vectors; other operands map to a fixed hash.
  function automatic logic [31:0] dp_fn(input logic [31:0] a, b, c);
    logic [95:0] k;
    k = {a, b, c};
    case (k)
      {32'h40000000, 32'h40400000, 32'h3F800000}: return 32'h40E00000; //  2*3+1
      {32'h40000000, 32'h40400000, 32'hBF800000}: return 32'h40A00000; //  2*3-1
      {32'hC0000000, 32'h40400000, 32'h3F800000}: return 32'hC0A00000; // -2*3+1
      {32'hC0000000, 32'h40400000, 32'hBF800000}: return 32'hC0E00000; // -2*3-1
      default: return (a ^ {b[15:0], b[31:16]} ^ c) + 32'h13579BDF;
    endcase
  endfunction

  // Result valid LAT cycles after the operands change, sampled at edge T+LAT.
  logic [W-1:0] pipe [1:LAT-1];
  always @(posedge clk) begin
    pipe[1] <= dp_fn(dp_a, dp_b, dp_c);
    for (int i = 2; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_res = pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [1:0] o,
                       input logic [31:0] a, b, c,
                       input logic [31:0] exp_a, exp_c, exp_res);
    in_valid = 1'b1; op = o; rs1 = a; rs2 = b; rs3 = c; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; op = ~o; rs1 = 32'hDEADBEEF; rs2 = 32'h0BADF00D; rs3 = 32'h12345678;
    chk({tag, "_dp_a"}, dp_a, exp_a);
    chk({tag, "_dp_b"}, dp_b, b);
    chk({tag, "_dp_c"}, dp_c, exp_c);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    repeat (LAT - 1) tick();
    chk({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_out_data"}, out_data, exp_res);
    chk({tag, "_dp_a_hold"}, dp_a, exp_a);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_drain_ready"}, {31'd0, in_ready}, 32'd1);
    $display("op %s: op=%b dp_a=%h dp_c=%h out_data=%h", tag, o, dp_a, dp_c, exp_res);
  endtask

  logic [1:0]  q_op  [3];
  logic [31:0] q_res [3];

  initial begin
    // Asynchronous reset before any clock edge.
    #3 resetn = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_dp_a", dp_a, 32'd0);
    chk("rst_dp_c", dp_c, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick(); tick();
    resetn = 1'b1;
    tick();

    do_op("fmadd",  2'b00, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40E00000);
    do_op("fmsub",  2'b01, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h40000000, 32'hBF800000, 32'h40A00000);
    do_op("fnmsub", 2'b10, 32'h40000000, 32'h40400000, 32'h3F800000, 32'hC0000000, 32'h3F800000, 32'hC0A00000);
    do_op("fnmadd", 2'b11, 32'h40000000, 32'h40400000, 32'h3F800000, 32'hC0000000, 32'hBF800000, 32'hC0E00000);
    do_op("nan",    2'b10, 32'h7FC00000, 32'h40400000, 32'h3F800000, 32'hFFC00000, 32'h3F800000,
          dp_fn(32'hFFC00000, 32'h40400000, 32'h3F800000));

    // Backpressure: result held under out_ready=0, new requests ignored.
    in_valid = 1'b1; op = 2'b00; rs1 = 32'h40000000; rs2 = 32'h40400000; rs3 = 32'h3F800000;
    tick();
    in_valid = 1'b0;
    repeat (LAT) tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data", out_data, 32'h40E00000);
      tick();
    end
    in_valid = 1'b1; op = 2'b11; rs1 = 32'h11111111; rs3 = 32'h22222222;
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("bp_ignored_dp_a", dp_a, 32'h40000000);
    chk("bp_ignored_dp_c", dp_c, 32'h3F800000);
    chk("bp_data_after_pulse", out_data, 32'h40E00000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    $display("backpressure: held 10 cycles, released");

    // Reset two cycles into WAIT.
    in_valid = 1'b1; op = 2'b01; rs1 = 32'h40000000; rs2 = 32'h40400000; rs3 = 32'h3F800000;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_dp_a", dp_a, 32'd0);
    chk("mid_rst_dp_b", dp_b, 32'd0);
    chk("mid_rst_dp_c", dp_c, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("mid_rst_no_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end
    $display("reset mid-WAIT: operation discarded");
    do_op("post_rst", 2'b11, 32'h40000000, 32'h40400000, 32'h3F800000, 32'hC0000000, 32'hBF800000, 32'hC0E00000);

    // Back-to-back with in_valid held high and out_ready high.
    q_op[0] = 2'b00; q_res[0] = 32'h40E00000;
    q_op[1] = 2'b11; q_res[1] = 32'hC0E00000;
    q_op[2] = 2'b01; q_res[2] = 32'h40A00000;
    begin
      int idx, nres, last;
      logic acc, hs;
      idx = 0; nres = 0; last = 0;
      rs1 = 32'h40000000; rs2 = 32'h40400000; rs3 = 32'h3F800000;
      op = q_op[0]; in_valid = 1'b1; out_ready = 1'b1;
      for (int cyc = 0; cyc < 60 && nres < 3; cyc++) begin
        acc = in_valid && in_ready;
        hs  = out_valid && out_ready;
        if (hs) begin
          chk("b2b_data", out_data, q_res[nres]);
          if (nres > 0) chk("b2b_spacing", cyc - last, LAT + 2);
          $display("b2b result %0d: cycle=%0d out_data=%h", nres, cyc, out_data);
          last = cyc;
          nres++;
        end
        tick();
        if (acc) begin
          idx++;
          if (idx < 3) op = q_op[idx];
          else in_valid = 1'b0;
        end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("b2b_result_count", nres, 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
